spi_mult_sequencer: RTL and testbench

Transaction sequencer for the SPI 4x4 multiplier peripheral. It receives one-cycle edge pulses and the conditioned chip-select from the input conditioners and drives the shift register's `mode` bus, the multiplier's `start` strobe and the MISO output-buffer enable. A transaction has three phases:
- shift in an 8-bit operand byte (B in [7:4], A in [3:0]);
- run the multiplier and wait for `done`, with a timeout;
- parallel-load the 8-bit product and shift it out.

---
 rtl/spi_mult_sequencer.sv | 125 ++++++++++++
 tb/tb_spi_mult_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mult_sequencer.sv
// Transaction sequencer for the SPI 4x4 multiplier peripheral.
// Receive operand, run multiplier with timeout, shift out product.
module spi_mult_sequencer #(
  parameter int OPW     = 8,
  parameter int RESW    = 8,
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk_posedge,
  input  logic       cs,
  input  logic       mult_done,
  output logic [1:0] mode,
  output logic       mult_start,
  output logic       miso_en,
  output logic       busy,
  output logic       err,
  output logic       xfer_done
);

  localparam int MAXW = (OPW > RESW) ? OPW : RESW;
  localparam int CW   = $clog2(MAXW + 1);
  localparam int TW   = $clog2(TIMEOUT + 1);

  localparam logic [1:0] M_HOLD  = 2'b00;
  localparam logic [1:0] M_SHIFT = 2'b01;
  localparam logic [1:0] M_LOAD  = 2'b10;

  typedef enum logic [2:0] {
    IDLE, RECV, START, WAIT,
    LOAD, SEND, DONE, ERR
  } state_t;

  state_t        st, nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [TW-1:0] tmr, tmr_nx;

  always_comb begin
    nx     = st;
    cnt_nx = cnt;
    tmr_nx = tmr;
    if (st != IDLE && cs) begin
      // cs rising beats every other event
      nx     = IDLE;
      cnt_nx = '0;
      tmr_nx = '0;
    end else begin
      unique case (st)
        IDLE: begin
          cnt_nx = '0;
          tmr_nx = '0;
          if (!cs) nx = RECV;
        end
        RECV: begin
          if (sclk_posedge) begin
            if (cnt == CW'(OPW - 1)) begin
              nx     = START;
              cnt_nx = '0;
            end else begin
              cnt_nx = cnt + CW'(1);
            end
          end
        end
        START: begin
          nx     = WAIT;
          tmr_nx = '0;
        end
        WAIT: begin
          if (mult_done) begin
            nx     = LOAD;
            tmr_nx = '0;
          end else if (tmr == TW'(TIMEOUT)) begin
            nx     = ERR;
            tmr_nx = '0;
          end else begin
            tmr_nx = tmr + TW'(1);
          end
        end
        LOAD: begin
          nx     = SEND;
          cnt_nx = '0;
        end
        SEND: begin
          if (sclk_posedge) begin
            if (cnt == CW'(RESW - 1)) begin
              nx     = DONE;
              cnt_nx = '0;
            end else begin
              cnt_nx = cnt + CW'(1);
            end
          end
        end
        DONE: nx = DONE;
        ERR:  nx = ERR;
      endcase
    end
  end

  // outputs registered from the next state so they track st exactly
  always_ff @(posedge clk) begin
    if (reset) begin
      st         <= IDLE;
      cnt        <= '0;
      tmr        <= '0;
      mode       <= M_HOLD;
      mult_start <= 1'b0;
      miso_en    <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      xfer_done  <= 1'b0;
    end else begin
      st         <= nx;
      cnt        <= cnt_nx;
      tmr        <= tmr_nx;
      mode       <= (nx == RECV || nx == SEND) ? M_SHIFT :
                    (nx == LOAD) ? M_LOAD : M_HOLD;
      mult_start <= (nx == START);
      miso_en    <= (nx == SEND);
      busy       <= (nx != IDLE);
      err        <= (nx == ERR);
      xfer_done  <= (nx == DONE) && (st != DONE);
    end
  end

endmodule

// File: tb/tb_spi_mult_sequencer.sv
// Bench for spi_mult_sequencer: randomized transactions against
// a per-cycle expected timeline built from the phase rules.
module tb_spi_mult_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       sclk_posedge;
  logic       cs;
  logic       mult_done;
  logic [1:0] mode;
  logic       mult_start;
  logic       miso_en;
  logic       busy;
  logic       err;
  logic       xfer_done;

  always #5 clk = ~clk;

  spi_mult_sequencer #(
    .OPW(8), .RESW(8), .TIMEOUT(15)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sclk_posedge(sclk_posedge),
    .cs(cs),
    .mult_done(mult_done),
    .mode(mode),
    .mult_start(mult_start),
    .miso_en(miso_en),
    .busy(busy),
    .err(err),
    .xfer_done(xfer_done)
  );

  // inputs of one cycle plus the outputs required in the next cycle
  typedef struct packed {
    logic       cs, sp, dn, rst;
    logic [1:0] mode;
    logic       st, me, bz, er, xd;
  } cyc_t;

  localparam int S_IDLE  = 0;
  localparam int S_RECV  = 1;
  localparam int S_START = 2;
  localparam int S_WAIT  = 3;
  localparam int S_LOAD  = 4;
  localparam int S_SEND  = 5;
  localparam int S_DONE1 = 6;
  localparam int S_DONE  = 7;
  localparam int S_ERR   = 8;

  cyc_t q[$];
  cyc_t plan[$];
  int   checks = 0;
  int   errors = 0;
  int   maxgap = 2;
  int   m_p5, m_p8, m_r3;

  function automatic bit rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic cyc_t mk(bit c, bit sp, bit dn, int s);
    cyc_t r;
    r    = '0;
    r.cs = c;
    r.sp = sp;
    r.dn = dn;
    case (s)
      S_RECV:  begin r.mode = 2'b01; r.bz = 1; end
      S_START: begin r.st = 1; r.bz = 1; end
      S_WAIT:  r.bz = 1;
      S_LOAD:  begin r.mode = 2'b10; r.bz = 1; end
      S_SEND:  begin r.mode = 2'b01; r.me = 1; r.bz = 1; end
      S_DONE1: begin r.xd = 1; r.bz = 1; end
      S_DONE:  r.bz = 1;
      S_ERR:   begin r.er = 1; r.bz = 1; end
      default: ;
    endcase
    return r;
  endfunction

  task automatic add(bit sp, bit dn, int s);
    q.push_back(mk(1'b0, sp, dn, s));
  endtask

  task automatic gap(int s);
    int n;
    n = $urandom_range(0, maxgap);
    repeat (n) add(1'b0, rnd(), s);
  endtask

  // lat > 15 means mult_done is withheld; wp forces pulses in WAIT
  task automatic build(int lat, int wp);
    q.delete();
    add(rnd(), rnd(), S_RECV);
    for (int k = 0; k < 8; k++) begin
      gap(S_RECV);
      add(1'b1, rnd(), (k == 7) ? S_START : S_RECV);
      if (k == 4) m_p5 = q.size();
      if (k == 7) m_p8 = q.size() - 1;
    end
    add(rnd(), rnd(), S_WAIT);
    for (int k = 0; k < 16; k++) begin
      if (k == lat) begin
        add(rnd(), 1'b1, S_LOAD);
        break;
      end
      add((k < wp) ? 1'b1 : rnd(), 1'b0,
          (k == 15) ? S_ERR : S_WAIT);
    end
    if (lat > 15) begin
      repeat (3) add(rnd(), rnd(), S_ERR);
    end else begin
      add(rnd(), rnd(), S_SEND);
      for (int k = 0; k < 8; k++) begin
        gap(S_SEND);
        add(1'b1, rnd(), (k == 7) ? S_DONE1 : S_SEND);
        if (k == 2) m_r3 = q.size();
      end
      repeat (2) add(rnd(), rnd(), S_DONE);
    end
    q.push_back(mk(1'b1, rnd(), rnd(), S_IDLE));
  endtask

  // cut >= 0: abort (cs high) or reset at that cycle
  task automatic emit(int cut, bit r);
    cyc_t c;
    if (cut < 0 || cut >= q.size()) begin
      foreach (q[i]) plan.push_back(q[i]);
    end else begin
      for (int i = 0; i < cut; i++) plan.push_back(q[i]);
      c = mk(r ? q[cut].cs : 1'b1, q[cut].sp, q[cut].dn, S_IDLE);
      c.rst = r;
      plan.push_back(c);
    end
  endtask

  task automatic idle(int n);
    repeat (n) plan.push_back(mk(1'b1, rnd(), rnd(), S_IDLE));
  endtask

  task automatic chk(string n, int cyc, int a, int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s cycle %0d got %0d expected %0d",
               n, cyc, a, e);
    end
  endtask

  task automatic compare(int cyc, cyc_t e);
    chk("mode", cyc, int'(mode), int'(e.mode));
    chk("mult_start", cyc, int'(mult_start), int'(e.st));
    chk("miso_en", cyc, int'(miso_en), int'(e.me));
    chk("busy", cyc, int'(busy), int'(e.bz));
    chk("err", cyc, int'(err), int'(e.er));
    chk("xfer_done", cyc, int'(xfer_done), int'(e.xd));
  endtask

  initial begin
    cyc_t c;
    int   lat, wp, sel, cut;
    c     = mk(1'b1, 1'b0, 1'b0, S_IDLE);
    c.rst = 1'b1;
    plan.push_back(c);
    plan.push_back(c);
    idle(2);

    // gapless builds pinned against hand-counted positions
    maxgap = 0;
    build(3, 0);
    chk("pin_len_normal", 0, q.size(), 26);
    chk("pin_start_idx", 0, int'(q[8].st), 1);
    chk("pin_load_mode", 0, int'(q[13].mode), 2);
    chk("pin_xfer_idx", 0, int'(q[22].xd), 1);
    emit(-1, 1'b0);
    idle(2);
    build(16, 0);
    chk("pin_len_timeout", 0, q.size(), 30);
    chk("pin_err_before", 0, int'(q[24].er), 0);
    chk("pin_err_at16", 0, int'(q[25].er), 1);
    emit(-1, 1'b0);
    idle(2);

    maxgap = 2;
    build(3, 0);  emit(m_p5, 1'b0); idle(2);
    build(2, 0);  emit(-1, 1'b0);   idle(2);
    build(3, 0);  emit(m_p8, 1'b0); idle(2);
    build(15, 0); emit(-1, 1'b0);   idle(2);
    build(6, 4);  emit(-1, 1'b0);   idle(2);
    build(3, 0);  emit(m_r3, 1'b1); idle(2);

    repeat (40) begin
      lat = $urandom_range(0, 17);
      wp  = $urandom_range(0, (lat < 16) ? lat : 16);
      build(lat, wp);
      sel = $urandom_range(0, 7);
      cut = $urandom_range(0, q.size() - 1);
      if (sel < 2)       emit(cut, 1'b0);
      else if (sel == 2) emit(cut, 1'b1);
      else               emit(-1, 1'b0);
      idle($urandom_range(1, 3));
    end

    reset        = 1'b1;
    cs           = 1'b1;
    sclk_posedge = 1'b0;
    mult_done    = 1'b0;
    foreach (plan[i]) begin
      @(negedge clk);
      if (i > 0) compare(i, plan[i-1]);
      reset        = plan[i].rst;
      cs           = plan[i].cs;
      sclk_posedge = plan[i].sp;
      mult_done    = plan[i].dn;
    end
    @(negedge clk);
    compare(plan.size(), plan[plan.size()-1]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
